// File: rtl/scene_command_sequencer.sv
// Scene command sequencer: walks the six receiver devices in ascending order
// and issues ON/OFF command strobes for every device whose state must change
// (or every masked device when forced). A shadow copy of the receiver's
// device state is used to skip commands that would change nothing.
module scene_command_sequencer #(
  parameter int GAP_CYCLES = 2,
  parameter int GAP_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scene_valid,
  input  logic [5:0] scene_target,
  input  logic [5:0] scene_mask,
  input  logic       scene_force,
  output logic       scene_ready,
  output logic       ok_google,
  output logic [3:0] mode,
  output logic       busy,
  output logic       done,
  output logic [5:0] shadow_state
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, GAP, DONE} state_t;

  localparam logic [3:0]       MODE_NOP = 4'd15;
  localparam logic [2:0]       LAST_DEV = 3'd5;
  // Counter is loaded with GAP_CYCLES-1 and counts down to zero, so GAP
  // occupies exactly GAP_CYCLES cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t           state;
  logic [5:0]       tgt_q;
  logic [5:0]       msk_q;
  logic             frc_q;
  logic [2:0]       ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             need;

  // A device needs a command if it is in the scene and either forced or out of step.
  assign need        = msk_q[ptr] & (frc_q | (tgt_q[ptr] != shadow_state[ptr]));
  assign scene_ready = (state == IDLE);

  // Sequencer FSM; every output except scene_ready is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tgt_q        <= '0;
      msk_q        <= '0;
      frc_q        <= 1'b0;
      ptr          <= '0;
      gap_cnt      <= '0;
      ok_google    <= 1'b0;
      mode         <= MODE_NOP;
      busy         <= 1'b0;
      done         <= 1'b0;
      shadow_state <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (scene_valid) begin
            tgt_q <= scene_target;
            msk_q <= scene_mask;
            frc_q <= scene_force;
            ptr   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (need) begin
            ok_google <= 1'b1;
            mode      <= {ptr, ~tgt_q[ptr]};  // 2*ptr for ON, 2*ptr+1 for OFF
            state     <= ISSUE;
          end else if (ptr == LAST_DEV) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ptr <= ptr + 3'd1;
          end
        end
        ISSUE: begin
          ok_google         <= 1'b0;
          mode              <= MODE_NOP;
          shadow_state[ptr] <= tgt_q[ptr];
          if (GAP_CYCLES > 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else if (ptr == LAST_DEV) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ptr   <= ptr + 3'd1;
            state <= SCAN;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (ptr == LAST_DEV) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ptr   <= ptr + 3'd1;
            state <= SCAN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
